cam_lookup_ctrl: RTL and testbench



---
 rtl/cam_pkg.sv | 23 ++
 rtl/cam_load_counter.sv | 38 +++
 rtl/cam_lookup_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cam_lookup_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and default sizes for the FIX-parser CAM lookup sequencer.
package cam_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CAM_DEPTH  = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    WAIT,
    RESP
  } lookup_state_t;

  // Captured lookup; win_end is already clamped to the last loaded entry.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] key;
    logic [DEF_ADDR_WIDTH-1:0] win_start;
    logic [DEF_ADDR_WIDTH-1:0] win_end;
    logic                      empty_win;
  } lookup_req_t;

endpackage

// File: rtl/cam_load_counter.sv
// Dictionary fill counter: accepts sequential loads while idle, and supplies
// the CAM write index and the current fill.
module cam_load_counter #(
  parameter int CAM_DEPTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load_valid,
  input  logic                  idle,
  output logic                  load_ready,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] write_index,
  output logic [ADDR_WIDTH:0]   fill
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(CAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic full;

  assign full        = (fill == DEPTH_C);
  assign load_ready  = idle && !full && !clear;
  assign write       = load_ready && load_valid;
  assign write_index = write ? fill[ADDR_WIDTH-1:0] : '0;

  // Clear outranks a simultaneous load, and acts in every FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fill <= '0;
    else if (clear)
      fill <= '0;
    else if (write)
      fill <= fill + ONE_C;
  end

endmodule

// File: rtl/cam_lookup_ctrl.sv
// CAM lookup sequencer: loads the tag dictionary and serves one windowed
// lookup at a time. Optional hit/miss counters under CAM_LOOKUP_STATS_EN.
module cam_lookup_ctrl
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CAM_DEPTH  = DEF_CAM_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SEARCH_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_clear_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  tag_valid_i,
  output logic                  tag_ready_o,
  input  logic [DATA_WIDTH-1:0] tag_data_i,
  input  logic [ADDR_WIDTH-1:0] tag_start_i,
  input  logic [ADDR_WIDTH-1:0] tag_end_i,
  output logic                  cam_write_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [DATA_WIDTH-1:0] cam_write_data_o,
  output logic                  cam_search_o,
  output logic [DATA_WIDTH-1:0] cam_search_data_o,
  output logic [ADDR_WIDTH-1:0] cam_start_o,
  output logic [ADDR_WIDTH-1:0] cam_end_o,
  input  logic                  cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  res_hit_o,
  output logic [ADDR_WIDTH-1:0] res_index_o,
  output logic [ADDR_WIDTH:0]   fill_o
`ifdef CAM_LOOKUP_STATS_EN
  ,
  output logic [15:0]           hit_cnt_o,
  output logic [15:0]           miss_cnt_o
`endif
);

  localparam logic [2:0]          LAT_INIT = 3'(SEARCH_LAT - 1);
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

  lookup_state_t         state, state_nxt;
  lookup_req_t           req_p0;
  logic [2:0]            lat_cnt;
  logic                  res_hit_p1;
  logic [ADDR_WIDTH-1:0] res_index_p1;

  logic                  idle;
  logic                  tag_acc;
  logic [ADDR_WIDTH:0]   last_idx;
  logic [ADDR_WIDTH-1:0] end_clamp;
  logic                  win_empty;

  assign idle = (state == IDLE);

  cam_load_counter #(
    .CAM_DEPTH  (CAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_load_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (load_clear_i),
    .load_valid  (load_valid_i),
    .idle        (idle),
    .load_ready  (load_ready_o),
    .write       (cam_write_o),
    .write_index (cam_write_index_o),
    .fill        (fill_o)
  );

  assign cam_write_data_o = cam_write_o ? load_data_i : '0;

  // A pending load always takes the cycle ahead of a lookup.
  assign tag_ready_o = idle && (!load_valid_i || !load_ready_o);
  assign tag_acc     = tag_valid_i && tag_ready_o;

  // Window clamp against the fill seen at accept; fill==0 makes last_idx wrap, but win_empty covers it.
  assign last_idx  = fill_o - ONE_C;
  assign end_clamp = ({1'b0, tag_end_i} > last_idx) ? last_idx[ADDR_WIDTH-1:0] : tag_end_i;
  assign win_empty = (fill_o == '0) || (tag_start_i > end_clamp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cam_search_o = 1'b0;
    res_valid_o  = 1'b0;
    case (state)
      IDLE: begin
        if (tag_acc)
          state_nxt = SEARCH;
      end
      SEARCH: begin
        cam_search_o = !req_p0.empty_win;
        state_nxt    = req_p0.empty_win ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0)
          state_nxt = RESP;
      end
      RESP: begin
        res_valid_o = 1'b1;
        if (res_ready_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lat_cnt <= '0;
    else if (state == SEARCH)
      lat_cnt <= LAT_INIT;
    else if (state == WAIT && lat_cnt != '0)
      lat_cnt <= lat_cnt - 3'd1;
  end

  // ---- stage p0: request capture at accept ----
  always_ff @(posedge clk) begin
    if (tag_acc) begin
      req_p0.key       <= tag_data_i;
      req_p0.win_start <= tag_start_i;
      req_p0.win_end   <= end_clamp;
      req_p0.empty_win <= win_empty;
    end
  end

  // ---- stage p1: result capture, index zeroed on a miss ----
  always_ff @(posedge clk) begin
    if (state == SEARCH && req_p0.empty_win) begin
      res_hit_p1   <= 1'b0;
      res_index_p1 <= '0;
    end else if (state == WAIT && lat_cnt == '0) begin
      res_hit_p1   <= cam_search_valid_i;
      res_index_p1 <= cam_search_valid_i ? cam_search_index_i : '0;
    end
  end

  // Data registers are unreset, so every output is gated by its qualifying state.
  assign cam_search_data_o = cam_search_o ? req_p0.key : '0;
  assign cam_start_o       = cam_search_o ? req_p0.win_start : '0;
  assign cam_end_o         = cam_search_o ? req_p0.win_end : '0;
  assign res_hit_o         = res_valid_o && res_hit_p1;
  assign res_index_o       = (res_valid_o && res_hit_p1) ? res_index_p1 : '0;

`ifdef CAM_LOOKUP_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (load_clear_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (res_valid_o && res_ready_i) begin
      if (res_hit_p1)
        hit_cnt_o <= sat_inc(hit_cnt_o);
      else
        miss_cnt_o <= sat_inc(miss_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Scoreboard bench for cam_lookup_ctrl with a behavioural CAM (SEARCH_LAT=1).
module tb_cam_lookup_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int LAT   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_clear_i = 1'b0;
  logic          load_valid_i = 1'b0;
  logic          load_ready_o;
  logic [DW-1:0] load_data_i = '0;
  logic          tag_valid_i = 1'b0;
  logic          tag_ready_o;
  logic [DW-1:0] tag_data_i = '0;
  logic [AW-1:0] tag_start_i = '0;
  logic [AW-1:0] tag_end_i = '0;
  logic          cam_write_o;
  logic [AW-1:0] cam_write_index_o;
  logic [DW-1:0] cam_write_data_o;
  logic          cam_search_o;
  logic [DW-1:0] cam_search_data_o;
  logic [AW-1:0] cam_start_o;
  logic [AW-1:0] cam_end_o;
  logic          cam_v_q = 1'b0;
  logic [AW-1:0] cam_i_q = '0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b1;
  logic          res_hit_o;
  logic [AW-1:0] res_index_o;
  logic [AW:0]   fill_o;
`ifdef CAM_LOOKUP_STATS_EN
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;
`endif

  always #5 clk = ~clk;

  cam_lookup_ctrl #(
    .DATA_WIDTH (DW),
    .CAM_DEPTH  (DEPTH),
    .ADDR_WIDTH (AW),
    .SEARCH_LAT (LAT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .load_clear_i       (load_clear_i),
    .load_valid_i       (load_valid_i),
    .load_ready_o       (load_ready_o),
    .load_data_i        (load_data_i),
    .tag_valid_i        (tag_valid_i),
    .tag_ready_o        (tag_ready_o),
    .tag_data_i         (tag_data_i),
    .tag_start_i        (tag_start_i),
    .tag_end_i          (tag_end_i),
    .cam_write_o        (cam_write_o),
    .cam_write_index_o  (cam_write_index_o),
    .cam_write_data_o   (cam_write_data_o),
    .cam_search_o       (cam_search_o),
    .cam_search_data_o  (cam_search_data_o),
    .cam_start_o        (cam_start_o),
    .cam_end_o          (cam_end_o),
    .cam_search_valid_i (cam_v_q),
    .cam_search_index_i (cam_i_q),
    .res_valid_o        (res_valid_o),
    .res_ready_i        (res_ready_i),
    .res_hit_o          (res_hit_o),
    .res_index_o        (res_index_o),
    .fill_o             (fill_o)
`ifdef CAM_LOOKUP_STATS_EN
    ,
    .hit_cnt_o          (hit_cnt),
    .miss_cnt_o         (miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writes_seen = 0;
  int search_pulses = 0;
  logic [DW-1:0] last_key = '0;
  logic [AW-1:0] last_start = '0;
  logic [AW-1:0] last_end = '0;
  logic [DW-1:0] mem [DEPTH];

  typedef struct packed { logic [AW-1:0] idx; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic hit; logic [AW-1:0] idx; } res_t;
  wr_t  wr_q[$];
  res_t res_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lowest matching index within the window wins.
  function automatic logic [AW:0] cam_find(input logic [DW-1:0] k, input logic [AW-1:0] s,
                                           input logic [AW-1:0] e);
    logic [AW:0] r = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (i >= int'(s) && i <= int'(e) && mem[i] === k) r = {1'b1, AW'(i)};
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CAM: result valid only in the cycle after the search strobe; junk index on miss.
  always @(posedge clk) begin
    if (cam_write_o) mem[cam_write_index_o] <= cam_write_data_o;
    if (cam_search_o) begin
      search_pulses <= search_pulses + 1;
      last_key      <= cam_search_data_o;
      last_start    <= cam_start_o;
      last_end      <= cam_end_o;
      cam_v_q       <= cam_find(cam_search_data_o, cam_start_o, cam_end_o) >> AW;
      cam_i_q       <= cam_find(cam_search_data_o, cam_start_o, cam_end_o) >> AW
                       ? cam_find(cam_search_data_o, cam_start_o, cam_end_o)
                       : {AW{1'b1}};
    end else begin
      cam_v_q <= 1'b0;
      cam_i_q <= AW'(21);
    end
  end

  // Write monitor.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (cam_write_o) begin
      writes_seen++;
      if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = wr_q.pop_front();
        chk("write_index", cam_write_index_o, e.idx);
        chk("write_data", cam_write_data_o, e.data);
      end
    end
  end

  // Result monitor.
  initial forever begin
    res_t e;
    @(negedge clk);
    if (res_valid_o && res_ready_i) begin
      if (res_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = res_q.pop_front();
        chk("res_hit", res_hit_o, e.hit);
        chk("res_index", res_index_o, e.idx);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic load_one(input logic [DW-1:0] d, input logic [AW-1:0] idx);
    wr_t w;
    w.idx = idx; w.data = d;
    wr_q.push_back(w);
    @(posedge clk); #1;
    load_valid_i = 1'b1; load_data_i = d;
    @(negedge clk);
    chk("load_ready", load_ready_o, 1);
  endtask

  task automatic load_stop();
    @(posedge clk); #1;
    load_valid_i = 1'b0; load_data_i = '0;
    @(negedge clk);
  endtask

  task automatic lookup(input logic [DW-1:0] key, input logic [AW-1:0] s, input logic [AW-1:0] e,
                        input logic exp_hit, input logic [AW-1:0] exp_idx, input int exp_lat,
                        input int exp_pulse, input logic [AW-1:0] exp_end, input int hold);
    res_t r;
    int p0, ca, n;
    bit seen;
    logic h;
    logic [AW-1:0] ix;
    r.hit = exp_hit; r.idx = exp_idx;
    res_q.push_back(r);
    p0 = search_pulses;
    @(posedge clk); #1;
    res_ready_i = (hold == 0);
    tag_valid_i = 1'b1; tag_data_i = key; tag_start_i = s; tag_end_i = e;
    @(negedge clk);
    chk("tag_accept", tag_ready_o, 1);
    ca = cyc;
    @(posedge clk); #1;
    tag_valid_i = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (res_valid_o) seen = 1; else n++;
    end
    if (!seen) chk("res_timeout", 0, 1);
    else chk("latency", 64'(cyc - ca), 64'(exp_lat));
    if (seen && hold > 0) begin
      h = res_hit_o; ix = res_index_o;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_valid", res_valid_o, 1);
        chk("hold_hit", res_hit_o, h);
        chk("hold_index", res_index_o, ix);
        chk("hold_no_accept", tag_ready_o, 0);
      end
      @(posedge clk); #1;
      res_ready_i = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("search_pulses", 64'(search_pulses - p0), 64'(exp_pulse));
    if (exp_pulse != 0) begin
      chk("cam_key", last_key, key);
      chk("cam_start", last_start, s);
      chk("cam_end", last_end, exp_end);
    end
    chk("back_idle", tag_ready_o, 1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_fill", fill_o, 0);
    chk("rst_cam_write", cam_write_o, 0);
    chk("rst_cam_search", cam_search_o, 0);
    chk("rst_load_ready", load_ready_o, 1);
    chk("rst_tag_ready", tag_ready_o, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three back-to-back loads
    load_one(32'h11, 0);
    load_one(32'h22, 1);
    load_one(32'h33, 2);
    load_stop();
    chk("fill_3", fill_o, 3);
    chk("writes_3", writes_seen, 3);

    lookup(32'h22, 0, 31, 1, 1, LAT + 2, 1, 2, 0);
    lookup(32'h33, 0, 1, 0, 0, LAT + 2, 1, 1, 0);
    lookup(32'h11, 5, 31, 0, 0, 2, 0, 0, 0);
    lookup(32'h11, 0, 31, 1, 0, LAT + 2, 1, 2, 0);

    // Fill to CAM_DEPTH
    for (int i = 0; i < DEPTH - 3; i++) load_one(32'h100 + DW'(i), AW'(i + 3));
    load_stop();
    chk("fill_full", fill_o, DEPTH);
    chk("full_not_ready", load_ready_o, 0);
    @(posedge clk); #1;
    load_valid_i = 1'b1; load_data_i = 32'hDEAD;
    @(negedge clk);
    chk("full_load_ready", load_ready_o, 0);
    chk("full_no_write", cam_write_o, 0);
    load_stop();
    chk("fill_stays_full", fill_o, DEPTH);
    lookup(32'h11C, 0, 31, 1, 31, LAT + 2, 1, 31, 0);

    // Clear in the same cycle as a load: clear wins
    @(posedge clk); #1;
    load_clear_i = 1'b1; load_valid_i = 1'b1; load_data_i = 32'hEE;
    @(negedge clk);
    chk("clear_load_ready", load_ready_o, 0);
    chk("clear_no_write", cam_write_o, 0);
    @(posedge clk); #1;
    load_clear_i = 1'b0; load_valid_i = 1'b0;
    @(negedge clk);
    chk("fill_cleared", fill_o, 0);

    lookup(32'h11, 0, 31, 0, 0, 2, 0, 0, 0);

    load_one(32'hAA, 0);
    load_stop();
    chk("fill_after_clear", fill_o, 1);

    // Load and tag together: load wins
    begin
      wr_t w;
      w.idx = 1; w.data = 32'hBB; wr_q.push_back(w);
      @(posedge clk); #1;
      load_valid_i = 1'b1; load_data_i = 32'hBB;
      tag_valid_i = 1'b1; tag_data_i = 32'hBB; tag_start_i = 0; tag_end_i = 31;
      @(negedge clk);
      chk("prio_tag_ready_0", tag_ready_o, 0);
      chk("prio_load_ready", load_ready_o, 1);
      w.idx = 2; w.data = 32'hCC; wr_q.push_back(w);
      @(posedge clk); #1;
      load_data_i = 32'hCC;
      @(negedge clk);
      chk("prio_tag_ready_1", tag_ready_o, 0);
      @(posedge clk); #1;
      load_valid_i = 1'b0; tag_valid_i = 1'b0;
      @(negedge clk);
      chk("prio_tag_ready_free", tag_ready_o, 1);
    end
    lookup(32'hBB, 0, 31, 1, 1, LAT + 2, 1, 2, 5);

    // Reset during WAIT
    @(posedge clk); #1;
    tag_valid_i = 1'b1; tag_data_i = 32'hCC; tag_start_i = 0; tag_end_i = 31;
    @(negedge clk);
    chk("rst_test_accept", tag_ready_o, 1);
    @(posedge clk); #1;
    tag_valid_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_res_valid", res_valid_o, 0);
    chk("async_rst_fill", fill_o, 0);
    chk("async_rst_search", cam_search_o, 0);
    chk("async_rst_tag_ready", tag_ready_o, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_result", res_valid_o, 0);
    end
    chk("post_rst_fill", fill_o, 0);
    chk("res_queue_empty", res_q.size(), 0);
    chk("wr_queue_empty", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
